// File: rtl/resp_frame_tx.sv
// Response-frame transmitter: emits FE, L, CMD, payload, EF into a UART TX
// byte interface, forwarding payload bytes straight from the source stream.
module resp_frame_tx #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] cmd_i,
    input  logic [7:0] len_i,
    input  logic [7:0] pay_data_i,
    input  logic       pay_valid_i,
    output logic       pay_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [7:0] MaxLen = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_FE  = 3'd1,
        SEND_L   = 3'd2,
        SEND_CMD = 3'd3,
        SEND_PAY = 3'd4,
        SEND_EF  = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic [7:0] len_sat;

    assign len_sat = (len_i > MaxLen) ? MaxLen : len_i;
    assign done_o  = done_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= 8'h00;
            len_q   <= 8'h00;
            cnt_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        tx_data_o   = 8'h00;
        tx_valid_o  = 1'b0;
        pay_ready_o = 1'b0;
        busy_o      = 1'b1;

        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    cmd_d   = cmd_i;
                    len_d   = len_sat;
                    cnt_d   = 8'h00;
                    state_d = SEND_FE;
                end
            end
            SEND_FE: begin
                tx_data_o  = 8'hFE;
                tx_valid_o = 1'b1;
                if (tx_ready_i) state_d = SEND_L;
            end
            SEND_L: begin
                tx_data_o  = len_q + 8'd2;
                tx_valid_o = 1'b1;
                if (tx_ready_i) state_d = SEND_CMD;
            end
            SEND_CMD: begin
                tx_data_o  = cmd_q;
                tx_valid_o = 1'b1;
                if (tx_ready_i) state_d = (len_q != 8'h00) ? SEND_PAY : SEND_EF;
            end
            SEND_PAY: begin
                // Payload passes through combinationally; the source holds it on a stall.
                tx_data_o   = pay_data_i;
                tx_valid_o  = pay_valid_i;
                pay_ready_o = tx_ready_i;
                if (pay_valid_i && tx_ready_i) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) state_d = SEND_EF;
                end
            end
            SEND_EF: begin
                tx_data_o  = 8'hEF;
                tx_valid_o = 1'b1;
                if (tx_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                busy_o  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_resp_frame_tx.sv
// Bench for resp_frame_tx: frames are predicted from the frame format as byte
// queues and compared against the bytes actually handed to the UART side.
module tb_resp_frame_tx;

    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    int tests  = 0;
    int failed = 0;

    resp_frame_tx #(.MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .cmd_i      (cmd),
        .len_i      (len),
        .pay_data_i (pay_data),
        .pay_valid_i(pay_valid),
        .pay_ready_o(pay_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame starting at posedge+1 in IDLE; returns at posedge+1 of the done cycle.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] l, input bit stall,
                              input int pbase);
        logic [7:0] exp_q[$];
        logic [7:0] src_q[$];
        logic [7:0] prev   = 8'h00;
        int         n, idx = 0, cycles = 0, consumed = 0, pr_cycles = 0;
        bit         held = 1'b0, last = 1'b0, popped;

        n = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
        for (int i = 0; i < n; i++)
            src_q.push_back((pbase >= 0) ? 8'(pbase + i + 1) : 8'($urandom));
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'(n + 2));
        exp_q.push_back(c);
        foreach (src_q[i]) exp_q.push_back(src_q[i]);
        exp_q.push_back(8'hEF);

        start = 1'b1; cmd = c; len = l; tx_ready = 1'b0; pay_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("fe_busy", busy, 1);
        check("fe_valid", tx_valid, 1);
        check("fe_data", tx_data, 8'hFE);

        while (!last && cycles < 1000) begin
            cycles++;
            check("no_early_done", done, 0);
            tx_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (src_q.size() > 0) begin
                if (!pay_valid) pay_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                pay_data = src_q[0];
            end else begin
                pay_valid = 1'b0;
                pay_data  = 8'($urandom);
            end
            if (stall && $urandom_range(0, 7) == 0) begin
                start = 1'b1; cmd = 8'($urandom); len = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            #1;
            if (held) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, prev);
            end
            if (pay_ready) pr_cycles++;
            popped = pay_valid && pay_ready;
            if (popped) begin
                check("pay_passthru", {tx_valid, tx_ready, tx_data}, {2'b11, src_q[0]});
                consumed++;
            end
            if (tx_valid && tx_ready) begin
                check($sformatf("byte%0d", idx), tx_data, exp_q[idx]);
                idx++;
                if (idx == exp_q.size()) last = 1'b1;
            end
            held = tx_valid && !tx_ready;
            prev = tx_data;
            @(posedge clk); #1;
            if (popped) begin
                void'(src_q.pop_front());
                pay_valid = 1'b0;
            end
        end
        start = 1'b0;
        check("frame_complete", last, 1);
        check("done_pulse", done, 1);
        check("done_not_busy", busy, 0);
        check("done_txv", tx_valid, 0);
        check("done_txd", tx_data, 8'h00);
        check("consumed", consumed, n);
        if (!stall) begin
            check("cycles_full_rate", cycles, n + 4);
            check("pay_ready_cycles", pr_cycles, n);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cmd = 8'h00; len = 8'h00;
        pay_data = 8'h00; pay_valid = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_txd", tx_data, 8'h00);
        check("rst_pay_ready", pay_ready, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        // Abandon a len=5 frame mid-payload with an asynchronous reset.
        start = 1'b1; cmd = 8'h22; len = 8'd5;
        tx_ready = 1'b1; pay_valid = 1'b1; pay_data = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("mid_pay_busy", busy, 1);
        check("mid_pay_ready", pay_ready, 1);
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_txv", tx_valid, 0);
        check("async_txd", tx_data, 8'h00);
        check("async_pay_ready", pay_ready, 0);
        check("async_done", done, 0);
        start = 1'b1;
        @(posedge clk); #1;
        check("reset_wins_busy", busy, 0);
        check("reset_wins_txv", tx_valid, 0);
        start = 1'b0; tx_ready = 1'b0; pay_valid = 1'b0;
        rst_n = 1'b1;

        send_frame(8'h03, 8'd0, 1'b0, -1);
        send_frame(8'h10, 8'd3, 1'b0, 8'hA0);
        send_frame(8'h10, 8'd3, 1'b1, 8'hA0);
        send_frame(8'h55, 8'd40, 1'b0, -1);
        send_frame(8'h56, 8'd40, 1'b1, -1);
        send_frame(8'hC0, 8'd0, 1'b0, -1);
        send_frame(8'hC1, 8'd0, 1'b0, -1);

        for (int f = 0; f < 24; f++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_frame(8'($urandom), 8'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), -1);
        end

        @(posedge clk); #1;
        check("final_idle_done", done, 0);
        check("final_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/resp_frame_tx.md
# resp_frame_tx

Response-frame transmitter: serializes a framed message, start byte 0xFE, length byte, command byte, 0..MAX_LEN payload bytes, end byte 0xEF, into the UART transmitter one byte at a time. It sits between the command-processing logic (frame request plus a payload byte stream) and the UART TX byte interface. It produces the same frame format that the command-frame parser on the receive path accepts.

## Interface
- MAX_LEN, default 16: maximum payload bytes per frame; legal range 0..253.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only while busy=0.
- cmd  in  8  command byte; captured on an accepted start.
- len  in  8  payload byte count; captured on an accepted start; values above MAX_LEN saturate to MAX_LEN.
- pay_data  in  8  payload byte from the source.
- pay_valid  in  1  pay_data is valid.
- pay_ready  out  1  payload byte consumed this cycle (pay_valid & pay_ready).
- tx_data  out  8  byte presented to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte this cycle (tx_valid & tx_ready).
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the EF byte is accepted.

## Operation
- States: IDLE, SEND_FE, SEND_L, SEND_CMD, SEND_PAY, SEND_EF.
- IDLE: start=1 captures cmd and the saturated len (len_q), clears the payload counter, and moves to SEND_FE.
- SEND_FE: tx_data=0xFE, tx_valid=1. On tx_ready, move to SEND_L.
- SEND_L: tx_data=len_q+2 (counts CMD, payload and EF; 8-bit, no overflow since MAX_LEN≤253), tx_valid=1. On tx_ready, move to SEND_CMD.
- SEND_CMD: tx_data=cmd_q, tx_valid=1. On tx_ready, move to SEND_PAY if len_q≠0, else to SEND_EF.
- SEND_PAY: tx_data=pay_data, tx_valid=pay_valid, pay_ready=tx_ready.
  - Each transfer (pay_valid & tx_ready) increments the counter.
  - On the transfer where counter==len_q-1, move to SEND_EF.
- SEND_EF: tx_data=0xEF, tx_valid=1. On tx_ready, move to IDLE and assert done for that next cycle.
- pay_ready is 0 in every state except SEND_PAY. Payload bytes are never consumed outside SEND_PAY and never dropped.
- tx_data and tx_valid hold steady while tx_valid=1 and tx_ready=0. In SEND_PAY the hold depends on the source holding pay_data.
- busy=1 in every state except IDLE.
- start while busy=1 is ignored, not queued.
- An invalid state encoding recovers to IDLE with outputs deasserted.

## Timing
- Reset (async assert, any state): state=IDLE, tx_valid=0, tx_data=0x00, pay_ready=0, busy=0, done=0. Counter and captured registers clear. A frame in flight is abandoned with no EF sent.
- In IDLE, tx_data=0x00 and tx_valid=0.
- start accepted at edge k: busy=1 and tx_valid=1 with tx_data=0xFE from cycle k+1.
- With tx_ready and pay_valid held at 1, a frame of N payload bytes occupies exactly N+4 cycles of tx_valid=1. done is high in cycle N+5 after start, and busy=0 in that same cycle.
- Back-to-back frames: start is accepted in the done cycle (state IDLE). There are no idle bytes between frames beyond that one cycle.
- A tx_ready stall or a pay_valid gap extends the current state only. There is no timeout.
- Simultaneous start and reset: reset wins.

## Test plan
- Reset mid-payload of a len=5 frame: all outputs go to their reset values immediately (asynchronous). After release, start with cmd=0x03 and len=0 yields bytes FE,02,03,EF, then done one cycle later.
- cmd=0x10, len=3, payload A1,A2,A3, tx_ready and pay_valid held at 1 -> bytes FE,05,10,A1,A2,A3,EF on 7 consecutive cycles. pay_ready is high on exactly 3 cycles. done occurs in cycle 8.
- Same frame with tx_ready toggling 1-0-0-1 and pay_valid gaps -> identical byte sequence. tx_data is stable during every stall, and no payload byte is duplicated or lost.
- len=40 with MAX_LEN=16 -> L byte is 0x12. Exactly 16 payload bytes are sent, then EF.
- start pulsed while busy -> no effect. A start in the done cycle begins a new FE on the next cycle.
- A back-to-back pair of len=0 frames -> FE,02,c0,EF,FE,02,c1,EF with exactly one tx_valid=0 cycle between them.
